id_ex_pipe: RTL and testbench



---
 rtl/id_ex_pipe_pkg.sv | 29 ++
 rtl/pipe_ctl_reg.sv | 30 +++
 rtl/id_ex_pipe.sv | 93 +++++++++
 tb/tb_id_ex_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Shared constants for the Y86 pipeline stage registers: instruction/register/status
// encodings, default field widths and the packed stage-bundle width helper.
package id_ex_pipe_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int PC_W_DEF   = 32;
  localparam int CODE_W_DEF = 4;
  localparam int REG_W_DEF  = 4;
  localparam int STAT_W_DEF = 3;
  localparam int CNT_W_DEF  = 16;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;

  localparam logic [3:0] R_NONE = 4'hF;

  localparam logic [2:0] S_BUB = 3'd0;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // icode, ifun, valA/valB/valC, valP, srcA/srcB/dstE/dstM, stat, valid
  function automatic int bundle_w(input int code_w, input int word_w, input int pc_w,
                                  input int reg_w, input int stat_w);
    return 2 * code_w + 3 * word_w + pc_w + 4 * reg_w + stat_w + 1;
  endfunction

endpackage

// File: rtl/pipe_ctl_reg.sv
// Generic pipeline stage register with reset, bubble injection and stall hold.
// Priority: rst > bubble > stall > load.
module pipe_ctl_reg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_p0;

  // stage p0: reset and bubble share the same load value
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= BUBBLE_VAL;
    end else if (bubble) begin
      data_p0 <= BUBBLE_VAL;
    end else if (!stall) begin
      data_p0 <= d;
    end
  end

  assign q = data_p0;

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX stage register for the pipelined Y86 core, with stall/bubble control,
// a valid flag travelling inside the bundle, and saturating stall/bubble counters.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int STAT_W = STAT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              bubble,
  input  logic              cnt_clr,
  input  logic [CODE_W-1:0] id_icode,
  input  logic [CODE_W-1:0] id_ifun,
  input  logic [WORD_W-1:0] id_valA,
  input  logic [WORD_W-1:0] id_valB,
  input  logic [WORD_W-1:0] id_valC,
  input  logic [PC_W-1:0]   id_valP,
  input  logic [REG_W-1:0]  id_srcA,
  input  logic [REG_W-1:0]  id_srcB,
  input  logic [REG_W-1:0]  id_dstE,
  input  logic [REG_W-1:0]  id_dstM,
  input  logic [STAT_W-1:0] id_stat,
  output logic [CODE_W-1:0] ex_icode,
  output logic [CODE_W-1:0] ex_ifun,
  output logic [WORD_W-1:0] ex_valA,
  output logic [WORD_W-1:0] ex_valB,
  output logic [WORD_W-1:0] ex_valC,
  output logic [PC_W-1:0]   ex_valP,
  output logic [REG_W-1:0]  ex_srcA,
  output logic [REG_W-1:0]  ex_srcB,
  output logic [REG_W-1:0]  ex_dstE,
  output logic [REG_W-1:0]  ex_dstM,
  output logic [STAT_W-1:0] ex_stat,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int BUN_W = bundle_w(CODE_W, WORD_W, PC_W, REG_W, STAT_W);

  localparam logic [BUN_W-1:0] NOP_BUN = {
    CODE_W'(I_NOP), CODE_W'(0),
    {(3 * WORD_W){1'b0}}, {PC_W{1'b0}},
    {4{REG_W'(R_NONE)}},
    STAT_W'(S_BUB),
    1'b0
  };

  logic [BUN_W-1:0] bun_d;
  logic [BUN_W-1:0] bun_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Valid is the LSB of the bundle, so stall/bubble treat it exactly like the data.
  assign bun_d = {id_icode, id_ifun, id_valA, id_valB, id_valC, id_valP,
                  id_srcA, id_srcB, id_dstE, id_dstM, id_stat, 1'b1};

  pipe_ctl_reg #(
    .WIDTH      (BUN_W),
    .BUBBLE_VAL (NOP_BUN)
  ) u_bundle (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .bubble (bubble),
    .d      (bun_d),
    .q      (bun_p0)
  );

  assign {ex_icode, ex_ifun, ex_valA, ex_valB, ex_valC, ex_valP,
          ex_srcA, ex_srcB, ex_dstE, ex_dstM, ex_stat, ex_valid} = bun_p0;

  // stage p0 counters: clear overrides any increment; bubble outranks stall
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (bubble) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end else if (stall) begin
      stall_cnt  <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: table-driven vectors plus hand sequences and random traffic,
// all scored against a reference model through an expected-value queue.
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  typedef struct {
    logic       rst, stall, bubble, clr;
    logic [3:0] icode, ifun;
    logic [31:0] valA, valB, valC, valP;
    logic [3:0] srcA, srcB, dstE, dstM;
    logic [2:0] stat;
  } in_t;

  typedef struct {
    logic [3:0] icode, ifun;
    logic [31:0] valA, valB, valC, valP;
    logic [3:0] srcA, srcB, dstE, dstM;
    logic [2:0] stat;
    logic       valid;
    int         scnt, bcnt, scnt2, bcnt2;
  } exp_t;

  typedef struct {
    in_t         i;
    logic [3:0]  e_icode;
    logic [31:0] e_valA;
    logic        e_valid;
    int          e_scnt;
    int          e_bcnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst, stall, bubble, cnt_clr;
  logic [3:0] id_icode, id_ifun, id_srcA, id_srcB, id_dstE, id_dstM;
  logic [31:0] id_valA, id_valB, id_valC, id_valP;
  logic [2:0] id_stat;

  logic [3:0] a_icode, a_ifun, a_srcA, a_srcB, a_dstE, a_dstM;
  logic [31:0] a_valA, a_valB, a_valC, a_valP;
  logic [2:0] a_stat;
  logic a_valid;
  logic [15:0] a_scnt, a_bcnt;

  logic [3:0] b_icode, b_ifun, b_srcA, b_srcB, b_dstE, b_dstM;
  logic [31:0] b_valA, b_valB, b_valC, b_valP;
  logic [2:0] b_stat;
  logic b_valid;
  logic [1:0] b_scnt, b_bcnt;

  int checks = 0;
  int errors = 0;
  exp_t m;
  exp_t exp_q[$];
  vec_t vt[19];

  always #5 clk = ~clk;

  id_ex_pipe #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .cnt_clr(cnt_clr),
    .id_icode(id_icode), .id_ifun(id_ifun), .id_valA(id_valA), .id_valB(id_valB),
    .id_valC(id_valC), .id_valP(id_valP), .id_srcA(id_srcA), .id_srcB(id_srcB),
    .id_dstE(id_dstE), .id_dstM(id_dstM), .id_stat(id_stat),
    .ex_icode(a_icode), .ex_ifun(a_ifun), .ex_valA(a_valA), .ex_valB(a_valB),
    .ex_valC(a_valC), .ex_valP(a_valP), .ex_srcA(a_srcA), .ex_srcB(a_srcB),
    .ex_dstE(a_dstE), .ex_dstM(a_dstM), .ex_stat(a_stat), .ex_valid(a_valid),
    .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
  );

  id_ex_pipe #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .cnt_clr(cnt_clr),
    .id_icode(id_icode), .id_ifun(id_ifun), .id_valA(id_valA), .id_valB(id_valB),
    .id_valC(id_valC), .id_valP(id_valP), .id_srcA(id_srcA), .id_srcB(id_srcB),
    .id_dstE(id_dstE), .id_dstM(id_dstM), .id_stat(id_stat),
    .ex_icode(b_icode), .ex_ifun(b_ifun), .ex_valA(b_valA), .ex_valB(b_valB),
    .ex_valC(b_valC), .ex_valP(b_valP), .ex_srcA(b_srcA), .ex_srcB(b_srcB),
    .ex_dstE(b_dstE), .ex_dstM(b_dstM), .ex_stat(b_stat), .ex_valid(b_valid),
    .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic r, input logic s, input logic b, input logic c,
                             input logic [3:0] icode, input logic [31:0] valA,
                             input logic [3:0] dstE);
    in_t v;
    v.rst = r; v.stall = s; v.bubble = b; v.clr = c;
    v.icode = icode; v.ifun = icode ^ 4'h5;
    v.valA = valA; v.valB = ~valA; v.valC = valA; v.valP = valA + 32'h100;
    v.dstE = dstE; v.srcA = dstE + 4'd1; v.srcB = dstE + 4'd2; v.dstM = dstE ^ 4'h8;
    v.stat = S_AOK;
    return v;
  endfunction

  function automatic int sat(input int c, input int w);
    return (c == (1 << w) - 1) ? c : c + 1;
  endfunction

  task automatic model(input in_t v);
    if (v.rst) begin
      m.icode = I_NOP; m.ifun = 4'h0; m.valA = '0; m.valB = '0; m.valC = '0; m.valP = '0;
      m.srcA = R_NONE; m.srcB = R_NONE; m.dstE = R_NONE; m.dstM = R_NONE;
      m.stat = S_BUB; m.valid = 1'b0;
      m.scnt = 0; m.bcnt = 0; m.scnt2 = 0; m.bcnt2 = 0;
    end else begin
      if (v.bubble) begin
        m.icode = I_NOP; m.ifun = 4'h0; m.valA = '0; m.valB = '0; m.valC = '0; m.valP = '0;
        m.srcA = R_NONE; m.srcB = R_NONE; m.dstE = R_NONE; m.dstM = R_NONE;
        m.stat = S_BUB; m.valid = 1'b0;
      end else if (!v.stall) begin
        m.icode = v.icode; m.ifun = v.ifun; m.valA = v.valA; m.valB = v.valB;
        m.valC = v.valC; m.valP = v.valP; m.srcA = v.srcA; m.srcB = v.srcB;
        m.dstE = v.dstE; m.dstM = v.dstM; m.stat = v.stat; m.valid = 1'b1;
      end
      if (v.clr) begin
        m.scnt = 0; m.bcnt = 0; m.scnt2 = 0; m.bcnt2 = 0;
      end else if (v.bubble) begin
        m.bcnt = sat(m.bcnt, 16); m.bcnt2 = sat(m.bcnt2, 2);
      end else if (v.stall) begin
        m.scnt = sat(m.scnt, 16); m.scnt2 = sat(m.scnt2, 2);
      end
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    chk("icode", 32'(a_icode), 32'(e.icode));
    chk("ifun", 32'(a_ifun), 32'(e.ifun));
    chk("valA", a_valA, e.valA);
    chk("valB", a_valB, e.valB);
    chk("valC", a_valC, e.valC);
    chk("valP", a_valP, e.valP);
    chk("srcA", 32'(a_srcA), 32'(e.srcA));
    chk("srcB", 32'(a_srcB), 32'(e.srcB));
    chk("dstE", 32'(a_dstE), 32'(e.dstE));
    chk("dstM", 32'(a_dstM), 32'(e.dstM));
    chk("stat", 32'(a_stat), 32'(e.stat));
    chk("valid", 32'(a_valid), 32'(e.valid));
    chk("stall_cnt", 32'(a_scnt), 32'(e.scnt));
    chk("bubble_cnt", 32'(a_bcnt), 32'(e.bcnt));
    chk("b_icode", 32'(b_icode), 32'(e.icode));
    chk("b_valid", 32'(b_valid), 32'(e.valid));
    chk("b_stall_cnt", 32'(b_scnt), 32'(e.scnt2));
    chk("b_bubble_cnt", 32'(b_bcnt), 32'(e.bcnt2));
  endtask

  // Drive one cycle of inputs, queue the model's prediction, score after the edge.
  task automatic step(input in_t v);
    rst = v.rst; stall = v.stall; bubble = v.bubble; cnt_clr = v.clr;
    id_icode = v.icode; id_ifun = v.ifun; id_valA = v.valA; id_valB = v.valB;
    id_valC = v.valC; id_valP = v.valP; id_srcA = v.srcA; id_srcB = v.srcB;
    id_dstE = v.dstE; id_dstM = v.dstM; id_stat = v.stat;
    model(v);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    in_t v;
    m = '{default: '0};
    //        rst   stl   bub   clr   icode  valA          dstE    e_icode e_valA        vld   s  b
    vt[0]  = '{mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 32'h7,        4'h2), 4'h1, 32'h0,        1'b0, 0, 0};
    vt[1]  = '{mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 32'h8,        4'h3), 4'h1, 32'h0,        1'b0, 0, 0};
    vt[2]  = '{mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 32'h1234,     4'h0), 4'h3, 32'h1234,     1'b1, 0, 0};
    vt[3]  = '{mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 32'h5,        4'h1), 4'h6, 32'h5,        1'b1, 0, 0};
    vt[4]  = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 32'h9,        4'h4), 4'h6, 32'h5,        1'b1, 1, 0};
    vt[5]  = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 32'hA,        4'h5), 4'h6, 32'h5,        1'b1, 2, 0};
    vt[6]  = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 32'hB,        4'h6), 4'h6, 32'h5,        1'b1, 3, 0};
    vt[7]  = '{mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 32'hC,        4'h7), 4'h7, 32'hC,        1'b1, 3, 0};
    vt[8]  = '{mk(1'b0, 1'b1, 1'b1, 1'b0, 4'h8, 32'hD,        4'h2), 4'h1, 32'h0,        1'b0, 3, 1};
    vt[9]  = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 32'hE,        4'h2), 4'h1, 32'h0,        1'b0, 4, 1};
    vt[10] = '{mk(1'b0, 1'b0, 1'b0, 1'b0, I_HALT, 32'hE,      4'h3), I_HALT, 32'hE,      1'b1, 4, 1};
    vt[11] = '{mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 32'hF,        4'h3), 4'h1, 32'h0,        1'b0, 4, 2};
    vt[12] = '{mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 32'h10,       4'h3), 4'h1, 32'h0,        1'b0, 0, 0};
    vt[13] = '{mk(1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 32'h11,       4'h3), 4'h1, 32'h0,        1'b0, 0, 0};
    vt[14] = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 32'h12,       4'h3), 4'h1, 32'h0,        1'b0, 1, 0};
    vt[15] = '{mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 32'h13,       4'h3), 4'h1, 32'h0,        1'b0, 0, 0};
    vt[16] = '{mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hB, 32'hDEADBEEF, 4'h9), 4'hB, 32'hDEADBEEF, 1'b1, 0, 0};
    vt[17] = '{mk(1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 32'h14,       4'h3), 4'h1, 32'h0,        1'b0, 0, 0};
    vt[18] = '{mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 32'hFFFFFFFF, 4'hF), 4'hC, 32'hFFFFFFFF, 1'b1, 0, 0};

    for (int k = 0; k < 19; k++) begin
      step(vt[k].i);
      chk($sformatf("tbl_icode[%0d]", k), 32'(a_icode), 32'(vt[k].e_icode));
      chk($sformatf("tbl_valA[%0d]", k), a_valA, vt[k].e_valA);
      chk($sformatf("tbl_valid[%0d]", k), 32'(a_valid), 32'(vt[k].e_valid));
      chk($sformatf("tbl_stall_cnt[%0d]", k), 32'(a_scnt), 32'(vt[k].e_scnt));
      chk($sformatf("tbl_bubble_cnt[%0d]", k), 32'(a_bcnt), 32'(vt[k].e_bcnt));
    end

    // 2-bit counters saturate at 3 and hold; clear wins over a concurrent stall
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 32'h5, 4'h1));
    for (int k = 0; k < 6; k++) step(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 32'(k), 4'h4));
    chk("sat_stall_cnt2", 32'(b_scnt), 32'd3);
    chk("sat_stall_cnt16", 32'(a_scnt), 32'd6);
    chk("sat_hold_valA", a_valA, 32'h5);
    step(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 32'h77, 4'h4));
    chk("sat_stall_cnt2_hold", 32'(b_scnt), 32'd3);
    step(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 32'h78, 4'h4));
    chk("clr_stall_cnt2", 32'(b_scnt), 32'd0);
    chk("clr_stall_cnt16", 32'(a_scnt), 32'd0);
    for (int k = 0; k < 5; k++) step(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 32'(k), 4'h4));
    chk("sat_bubble_cnt2", 32'(b_bcnt), 32'd3);
    chk("sat_bubble_cnt16", 32'(a_bcnt), 32'd5);

    // Unknown stall/bubble while in reset must leave clean reset state
    v = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 32'hABCD, 4'h2);
    v.stall = 1'bx; v.bubble = 1'bx;
    step(v);
    chk("x_rst_icode", 32'(a_icode), 32'(I_NOP));
    chk("x_rst_valid", 32'(a_valid), 32'd0);
    chk("x_rst_stall_cnt", 32'(a_scnt), 32'd0);
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 32'h55AA, 4'h6));
    chk("after_rst_load", a_valA, 32'h55AA);

    for (int k = 0; k < 80; k++) begin
      v.rst    = ($urandom_range(0, 15) == 0);
      v.stall  = ($urandom_range(0, 2) == 0);
      v.bubble = ($urandom_range(0, 4) == 0);
      v.clr    = ($urandom_range(0, 9) == 0);
      v.icode = 4'($urandom); v.ifun = 4'($urandom);
      v.valA = $urandom; v.valB = $urandom; v.valC = $urandom; v.valP = $urandom;
      v.srcA = 4'($urandom); v.srcB = 4'($urandom);
      v.dstE = 4'($urandom); v.dstM = 4'($urandom);
      v.stat = 3'($urandom_range(1, 4));
      step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
